modrm_agu: RTL and testbench

//  Parametrised ModRM decode + address-generation unit for the x86 core. On start it pulls the ModRM

---
 rtl/modrm_agu.sv | 261 ++++++++++++++++++++++++++
 tb/tb_modrm_agu.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modrm_agu.sv
// ModRM decode and address generation: consumes the ModRM and displacement bytes, selects the
// register operands, forms EA and the segmented physical address, optionally fetches the operand.
module modrm_agu #(
  parameter int unsigned PHYS_AW   = 20,
  parameter int unsigned FETCH_MEM = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_locked,
  input  logic               i_start,
  input  logic               i_size,
  input  logic               i_dir,
  input  logic               i_ovr_en,
  input  logic [15:0]        i_ovr_seg,
  input  logic [15:0]        i_ds_seg,
  input  logic [15:0]        i_ss_seg,
  input  logic [127:0]       i_regs,
  input  logic [7:0]         i_ib_data,
  input  logic               i_ib_valid,
  output logic               o_ib_ready,
  output logic [PHYS_AW-1:0] o_mem_addr,
  output logic               o_mem_rd,
  input  logic [7:0]         i_mem_in,
  output logic               o_busy,
  output logic               o_done,
  output logic [7:0]         o_modrm,
  output logic [15:0]        o_op1,
  output logic [15:0]        o_op2,
  output logic [15:0]        o_ea,
  output logic [PHYS_AW-1:0] o_phys,
  output logic               o_is_mem,
  output logic [1:0]         o_ip_inc
);

  typedef enum logic [2:0] {
    StIdle, StModrm, StDispLo, StDispHi, StMemLo, StMemHi, StDone
  } state_e;

  localparam state_e MemPhase = (FETCH_MEM != 0) ? StMemLo : StDone;

  state_e      r_state, w_state_nxt;
  logic        r_size, w_size_nxt;
  logic        r_dir, w_dir_nxt;
  logic        r_ovr_en, w_ovr_en_nxt;
  logic [15:0] r_ovr_seg, w_ovr_seg_nxt;
  logic        r_disp16, w_disp16_nxt;
  logic        r_wait, w_wait_nxt;
  logic        r_is_mem, w_is_mem_nxt;
  logic [15:0] r_seg, w_seg_nxt;
  logic [15:0] r_base, w_base_nxt;
  logic [15:0] r_disp, w_disp_nxt;
  logic [15:0] r_reg_val, w_reg_val_nxt;
  logic [15:0] r_rm_val, w_rm_val_nxt;
  logic [7:0]  r_modrm, w_modrm_nxt;
  logic [1:0]  r_ip_inc, w_ip_inc_nxt;

  logic [1:0]         w_mod;
  logic [2:0]         w_reg;
  logic [2:0]         w_rm;
  logic [15:0]        w_ea;
  logic [PHYS_AW-1:0] w_phys;
  logic [PHYS_AW-1:0] w_phys_hi;

  // Byte registers 4-7 are the high halves of ax..bx.
  function automatic logic [15:0] reg_value(input logic [127:0] regs, input logic size,
                                            input logic [2:0] idx);
    logic [15:0] word;
    if (size) begin
      word = regs[{idx, 4'h0} +: 16];
      return word;
    end
    word = regs[{1'b0, idx[1:0], 4'h0} +: 16];
    return idx[2] ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
  endfunction

  function automatic logic [15:0] ea_base(input logic [127:0] regs, input logic [2:0] rm,
                                          input logic [1:0] mod);
    logic [15:0] bx, bp, si, di;
    bx = regs[63:48];
    bp = regs[95:80];
    si = regs[111:96];
    di = regs[127:112];
    unique case (rm)
      3'd0: return bx + si;
      3'd1: return bx + di;
      3'd2: return bp + si;
      3'd3: return bp + di;
      3'd4: return si;
      3'd5: return di;
      3'd6: return (mod == 2'b00) ? 16'h0000 : bp;
      default: return bx;
    endcase
  endfunction

  function automatic logic [PHYS_AW-1:0] seg_phys(input logic [15:0] seg, input logic [15:0] off);
    logic [PHYS_AW+19:0] sum;
    if (PHYS_AW == 16) return PHYS_AW'(off);
    sum = {{PHYS_AW{1'b0}}, seg, 4'h0} + {{(PHYS_AW + 4){1'b0}}, off};
    return PHYS_AW'(sum);
  endfunction

  assign w_mod = i_ib_data[7:6];
  assign w_reg = i_ib_data[5:3];
  assign w_rm  = i_ib_data[2:0];

  always_ff @(posedge clock) begin
    if (i_locked) begin
      if (!reset_n) begin
        r_state   <= StIdle;
        r_size    <= 1'b0;
        r_dir     <= 1'b0;
        r_ovr_en  <= 1'b0;
        r_ovr_seg <= 16'h0000;
        r_disp16  <= 1'b0;
        r_wait    <= 1'b0;
        r_is_mem  <= 1'b0;
        r_seg     <= 16'h0000;
        r_base    <= 16'h0000;
        r_disp    <= 16'h0000;
        r_reg_val <= 16'h0000;
        r_rm_val  <= 16'h0000;
        r_modrm   <= 8'h00;
        r_ip_inc  <= 2'd0;
      end else begin
        r_state   <= w_state_nxt;
        r_size    <= w_size_nxt;
        r_dir     <= w_dir_nxt;
        r_ovr_en  <= w_ovr_en_nxt;
        r_ovr_seg <= w_ovr_seg_nxt;
        r_disp16  <= w_disp16_nxt;
        r_wait    <= w_wait_nxt;
        r_is_mem  <= w_is_mem_nxt;
        r_seg     <= w_seg_nxt;
        r_base    <= w_base_nxt;
        r_disp    <= w_disp_nxt;
        r_reg_val <= w_reg_val_nxt;
        r_rm_val  <= w_rm_val_nxt;
        r_modrm   <= w_modrm_nxt;
        r_ip_inc  <= w_ip_inc_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_size_nxt    = r_size;
    w_dir_nxt     = r_dir;
    w_ovr_en_nxt  = r_ovr_en;
    w_ovr_seg_nxt = r_ovr_seg;
    w_disp16_nxt  = r_disp16;
    w_wait_nxt    = r_wait;
    w_is_mem_nxt  = r_is_mem;
    w_seg_nxt     = r_seg;
    w_base_nxt    = r_base;
    w_disp_nxt    = r_disp;
    w_reg_val_nxt = r_reg_val;
    w_rm_val_nxt  = r_rm_val;
    w_modrm_nxt   = r_modrm;
    w_ip_inc_nxt  = r_ip_inc;
    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_nxt   = StModrm;
          w_size_nxt    = i_size;
          w_dir_nxt     = i_dir;
          w_ovr_en_nxt  = i_ovr_en;
          w_ovr_seg_nxt = i_ovr_seg;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      StModrm: begin
        if (i_ib_valid) begin
          w_modrm_nxt   = i_ib_data;
          w_reg_val_nxt = reg_value(i_regs, r_size, w_reg);
          w_ip_inc_nxt  = 2'd1;
          w_disp_nxt    = 16'h0000;
          w_wait_nxt    = 1'b0;
          if (w_mod == 2'b11) begin
            w_is_mem_nxt = 1'b0;
            w_rm_val_nxt = reg_value(i_regs, r_size, w_rm);
            w_base_nxt   = 16'h0000;
            w_seg_nxt    = 16'h0000;
            w_disp16_nxt = 1'b0;
            w_state_nxt  = StDone;
          end else begin
            w_is_mem_nxt = 1'b1;
            w_rm_val_nxt = 16'h0000;
            w_base_nxt   = ea_base(i_regs, w_rm, w_mod);
            if (r_ovr_en) begin
              w_seg_nxt = r_ovr_seg;
            end else if (w_rm == 3'd2 || w_rm == 3'd3 || (w_rm == 3'd6 && w_mod != 2'b00)) begin
              w_seg_nxt = i_ss_seg;
            end else begin
              w_seg_nxt = i_ds_seg;
            end
            w_disp16_nxt = (w_mod == 2'b10) || (w_mod == 2'b00 && w_rm == 3'd6);
            if (w_mod == 2'b00 && w_rm != 3'd6) begin
              w_state_nxt = MemPhase;
            end else begin
              w_state_nxt = StDispLo;
            end
          end
        end
      end
      StDispLo: begin
        if (i_ib_valid) begin
          w_ip_inc_nxt = 2'd2;
          if (r_disp16) begin
            w_disp_nxt  = {8'h00, i_ib_data};
            w_state_nxt = StDispHi;
          end else begin
            w_disp_nxt  = {{8{i_ib_data[7]}}, i_ib_data};
            w_state_nxt = MemPhase;
          end
        end
      end
      StDispHi: begin
        if (i_ib_valid) begin
          w_ip_inc_nxt = 2'd3;
          w_disp_nxt   = {i_ib_data, r_disp[7:0]};
          w_state_nxt  = MemPhase;
        end
      end
      // Each byte takes a strobe cycle then a capture cycle (read data lags by one).
      StMemLo: begin
        w_wait_nxt = ~r_wait;
        if (r_wait) begin
          w_rm_val_nxt = {r_rm_val[15:8], i_mem_in};
          w_state_nxt  = r_size ? StMemHi : StDone;
        end
      end
      StMemHi: begin
        w_wait_nxt = ~r_wait;
        if (r_wait) begin
          w_rm_val_nxt = {i_mem_in, r_rm_val[7:0]};
          w_state_nxt  = StDone;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_ea      = r_base + r_disp;
  assign w_phys    = seg_phys(r_seg, w_ea);
  assign w_phys_hi = seg_phys(r_seg, w_ea + 16'd1);

  assign o_busy     = (r_state != StIdle) && (r_state != StDone);
  assign o_done     = (r_state == StDone);
  assign o_ib_ready = (r_state == StModrm) || (r_state == StDispLo) || (r_state == StDispHi);
  assign o_mem_rd   = ((r_state == StMemLo) || (r_state == StMemHi)) && !r_wait;
  assign o_mem_addr = !o_mem_rd ? '0 : (r_state == StMemHi) ? w_phys_hi : w_phys;
  assign o_modrm    = r_modrm;
  assign o_op1      = r_dir ? r_reg_val : r_rm_val;
  assign o_op2      = r_dir ? r_rm_val : r_reg_val;
  assign o_ea       = w_ea;
  assign o_phys     = w_phys;
  assign o_is_mem   = r_is_mem;
  assign o_ip_inc   = r_ip_inc;

endmodule

// File: tb/tb_modrm_agu.sv
// Self-checking bench for modrm_agu: directed vector table, randomized ops against a
// behavioural model, and hand-written reset/stall/lock sequences.
module tb_modrm_agu;

  typedef struct {
    logic         size, dir, ovr_en;
    logic [15:0]  ovr_seg, ds, ss;
    logic [127:0] regs;
    logic [7:0]   modrm;
    logic [15:0]  disp;
    int           stall_at, stall_len, lock_at, lock_len;
  } op_t;

  typedef struct {
    logic [15:0] op1, op2, ea;
    logic [19:0] phys;
    logic        is_mem;
    logic [1:0]  ip_inc;
    int          lat, nrd;
    logic [19:0] a0, a1;
  } res_t;

  typedef struct {
    string name;
    op_t   op;
    res_t  exp;
  } vec_t;

  logic         clock = 1'b0;
  logic         reset_n, i_locked, i_start, i_size, i_dir, i_ovr_en;
  logic [15:0]  i_ovr_seg, i_ds_seg, i_ss_seg;
  logic [127:0] i_regs;
  logic [7:0]   i_ib_data;
  logic         i_ib_valid, o_ib_ready;
  logic [19:0]  o_mem_addr;
  logic         o_mem_rd;
  logic [7:0]   i_mem_in = 8'h00;
  logic         o_busy, o_done;
  logic [7:0]   o_modrm;
  logic [15:0]  o_op1, o_op2, o_ea;
  logic [19:0]  o_phys;
  logic         o_is_mem;
  logic [1:0]   o_ip_inc;

  int n_pass = 0;
  int n_checks = 0;
  logic [7:0] mem_ovr [int];
  vec_t vecs[$];

  modrm_agu #(.PHYS_AW(20), .FETCH_MEM(1)) dut (
    .clock(clock), .reset_n(reset_n), .i_locked(i_locked), .i_start(i_start),
    .i_size(i_size), .i_dir(i_dir), .i_ovr_en(i_ovr_en), .i_ovr_seg(i_ovr_seg),
    .i_ds_seg(i_ds_seg), .i_ss_seg(i_ss_seg), .i_regs(i_regs), .i_ib_data(i_ib_data),
    .i_ib_valid(i_ib_valid), .o_ib_ready(o_ib_ready), .o_mem_addr(o_mem_addr),
    .o_mem_rd(o_mem_rd), .i_mem_in(i_mem_in), .o_busy(o_busy), .o_done(o_done),
    .o_modrm(o_modrm), .o_op1(o_op1), .o_op2(o_op2), .o_ea(o_ea), .o_phys(o_phys),
    .o_is_mem(o_is_mem), .o_ip_inc(o_ip_inc)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_at(input logic [19:0] a);
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h5A;
  endfunction

  // Read data appears one cycle after the strobe; junk otherwise to expose timing slips.
  always @(posedge clock) begin
    if (i_locked) i_mem_in <= o_mem_rd ? mem_at(o_mem_addr) : 8'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int unsigned word_of(input logic [127:0] r, input int unsigned i);
    logic [127:0] s;
    s = r >> (16 * i);
    return 32'(s[15:0]);
  endfunction

  function automatic int unsigned reg_val(input logic [127:0] r, input logic size,
                                          input int unsigned i);
    if (size) return word_of(r, i);
    return (word_of(r, i % 4) >> (8 * (i / 4))) & 32'hFF;
  endfunction

  function automatic res_t model(input op_t op);
    res_t e;
    int unsigned md, rg, rm, base, dv, ea, seg, phys, hi, memv, rmv, regv, nd;
    md = 32'(op.modrm[7:6]);
    rg = 32'(op.modrm[5:3]);
    rm = 32'(op.modrm[2:0]);
    case (rm)
      0: base = word_of(op.regs, 3) + word_of(op.regs, 6);
      1: base = word_of(op.regs, 3) + word_of(op.regs, 7);
      2: base = word_of(op.regs, 5) + word_of(op.regs, 6);
      3: base = word_of(op.regs, 5) + word_of(op.regs, 7);
      4: base = word_of(op.regs, 6);
      5: base = word_of(op.regs, 7);
      6: base = (md == 0) ? 0 : word_of(op.regs, 5);
      default: base = word_of(op.regs, 3);
    endcase
    nd = (md == 1) ? 1 : ((md == 2) || (md == 0 && rm == 6)) ? 2 : 0;
    if (nd == 1) dv = op.disp[7] ? 32'(op.disp[7:0]) + 32'hFF00 : 32'(op.disp[7:0]);
    else if (nd == 2) dv = 32'(op.disp);
    else dv = 0;
    ea = (base + dv) % 65536;
    if (op.ovr_en) seg = 32'(op.ovr_seg);
    else if (rm == 2 || rm == 3 || (rm == 6 && md != 0)) seg = 32'(op.ss);
    else seg = 32'(op.ds);
    phys = (seg * 16 + ea) % (1 << 20);
    hi   = (seg * 16 + (ea + 1) % 65536) % (1 << 20);
    memv = 32'(mem_at(20'(phys))) + (op.size ? 256 * 32'(mem_at(20'(hi))) : 0);
    rmv  = (md == 3) ? reg_val(op.regs, op.size, rm) : memv;
    regv = reg_val(op.regs, op.size, rg);
    e.op1    = 16'(op.dir ? regv : rmv);
    e.op2    = 16'(op.dir ? rmv : regv);
    e.is_mem = (md != 3);
    e.ea     = (md == 3) ? 16'h0 : 16'(ea);
    e.phys   = 20'(phys);
    e.ip_inc = 2'(1 + nd);
    e.nrd    = (md == 3) ? 0 : (op.size ? 2 : 1);
    e.a0     = 20'(phys);
    e.a1     = 20'(hi);
    e.lat    = 2 + int'(nd) + 2 * e.nrd + op.lock_len
             + ((op.stall_at < int'(1 + nd)) ? op.stall_len : 0);
    return e;
  endfunction

  function automatic op_t mk_op(input logic size, input logic dir, input logic ovr_en,
                                input logic [15:0] ovr_seg, input logic [15:0] ds,
                                input logic [15:0] ss, input logic [127:0] regs,
                                input logic [7:0] modrm, input logic [15:0] disp,
                                input int stall_at, input int stall_len,
                                input int lock_at, input int lock_len);
    op_t o;
    o.size = size; o.dir = dir; o.ovr_en = ovr_en; o.ovr_seg = ovr_seg; o.ds = ds; o.ss = ss;
    o.regs = regs; o.modrm = modrm; o.disp = disp; o.stall_at = stall_at;
    o.stall_len = stall_len; o.lock_at = lock_at; o.lock_len = lock_len;
    return o;
  endfunction

  function automatic res_t mk_res(input logic [15:0] op1, input logic [15:0] op2,
                                  input logic [15:0] ea, input logic [19:0] phys,
                                  input logic is_mem, input logic [1:0] ip_inc, input int lat,
                                  input int nrd, input logic [19:0] a0, input logic [19:0] a1);
    res_t r;
    r.op1 = op1; r.op2 = op2; r.ea = ea; r.phys = phys; r.is_mem = is_mem;
    r.ip_inc = ip_inc; r.lat = lat; r.nrd = nrd; r.a0 = a0; r.a1 = a1;
    return r;
  endfunction

  task automatic run_op(input op_t op, input res_t exp, input string tag);
    logic [7:0]  bytes [3];
    logic [19:0] rds[$];
    int idx = 0;
    int stall_rem = op.stall_len;
    int cyc = 1;
    int done_cyc = -1;
    logic lk, vld;
    bytes[0] = op.modrm; bytes[1] = op.disp[7:0]; bytes[2] = op.disp[15:8];
    @(negedge clock);
    i_size = op.size; i_dir = op.dir; i_ovr_en = op.ovr_en; i_ovr_seg = op.ovr_seg;
    i_ds_seg = op.ds; i_ss_seg = op.ss; i_regs = op.regs;
    i_locked = 1'b1; i_start = 1'b1; i_ib_valid = 1'b0;
    @(negedge clock);
    i_start = 1'b0;
    while (cyc < 80) begin
      if (o_done) begin
        done_cyc = cyc;
        break;
      end
      lk = !(op.lock_len > 0 && cyc >= op.lock_at && cyc < op.lock_at + op.lock_len);
      i_locked = lk;
      if (!lk) check({tag, ".busy_locked"}, 32'(o_busy), 32'd1);
      vld = (idx < 3);
      if (lk && vld && idx == op.stall_at && stall_rem > 0) begin
        vld = 1'b0;
        stall_rem--;
        check({tag, ".ready_stalled"}, 32'(o_ib_ready), 32'd1);
      end
      i_ib_valid = vld;
      i_ib_data = (idx < 3) ? bytes[idx] : 8'h00;
      if (lk && o_mem_rd) rds.push_back(o_mem_addr);
      @(negedge clock);
      if (lk && vld && o_ib_ready) idx++;
      cyc++;
    end
    i_locked = 1'b1;
    i_ib_valid = 1'b0;
    check({tag, ".latency"}, 32'(done_cyc), 32'(exp.lat));
    check({tag, ".modrm"}, 32'(o_modrm), 32'(op.modrm));
    check({tag, ".op1"}, 32'(o_op1), 32'(exp.op1));
    check({tag, ".op2"}, 32'(o_op2), 32'(exp.op2));
    check({tag, ".ea"}, 32'(o_ea), 32'(exp.ea));
    check({tag, ".is_mem"}, 32'(o_is_mem), 32'(exp.is_mem));
    check({tag, ".ip_inc"}, 32'(o_ip_inc), 32'(exp.ip_inc));
    if (exp.is_mem) check({tag, ".phys"}, 32'(o_phys), 32'(exp.phys));
    check({tag, ".nreads"}, 32'(rds.size()), 32'(exp.nrd));
    if (exp.nrd >= 1 && rds.size() >= 1) check({tag, ".addr_lo"}, 32'(rds[0]), 32'(exp.a0));
    if (exp.nrd >= 2 && rds.size() >= 2) check({tag, ".addr_hi"}, 32'(rds[1]), 32'(exp.a1));
    @(negedge clock);
    check({tag, ".done_pulse"}, {30'd0, o_done, o_busy}, 32'd0);
    check({tag, ".hold_op1"}, 32'(o_op1), 32'(exp.op1));
  endtask

  initial begin
    op_t  op;
    res_t e;
    int   dones;
    reset_n = 1'b0; i_locked = 1'b1; i_start = 1'b0; i_size = 1'b0; i_dir = 1'b0;
    i_ovr_en = 1'b0; i_ovr_seg = '0; i_ds_seg = '0; i_ss_seg = '0; i_regs = '0;
    i_ib_data = '0; i_ib_valid = 1'b0;
    mem_ovr[32'h20100] = 8'h34; mem_ovr[32'h20101] = 8'h12;
    mem_ovr[32'h0FFFF] = 8'hAA; mem_ovr[32'h00000] = 8'h55;
    mem_ovr[32'h1FFFF] = 8'h77; mem_ovr[32'h10000] = 8'h66;
    mem_ovr[32'h03345] = 8'h9A;

    vecs.push_back('{"word_rr",
      mk_op(1, 1, 0, 16'h0, 16'h0, 16'h0, 128'h0000_0000_0000_0000_5678_0000_0000_1234,
            8'hC3, 16'h0, -1, 0, 0, 0),
      mk_res(16'h1234, 16'h5678, 16'h0, 20'h0, 0, 2'd1, 2, 0, 20'h0, 20'h0)});
    vecs.push_back('{"byte_rr",
      mk_op(0, 0, 0, 16'h0, 16'h0, 16'h0, 128'h0000_0000_0000_0000_0000_0000_0000_ABCD,
            8'hE0, 16'h0, -1, 0, 0, 0),
      mk_res(16'h00CD, 16'h00AB, 16'h0, 20'h0, 0, 2'd1, 2, 0, 20'h0, 20'h0)});
    vecs.push_back('{"bp_si_d8",
      mk_op(1, 1, 0, 16'h0, 16'h3000, 16'h2000, 128'h0000_0010_0100_0000_0000_0000_0000_BEEF,
            8'h42, 16'h00F0, -1, 0, 0, 0),
      mk_res(16'hBEEF, 16'h1234, 16'h0100, 20'h20100, 1, 2'd2, 7, 2, 20'h20100, 20'h20101)});
    vecs.push_back('{"seg_wrap",
      mk_op(1, 1, 0, 16'h0, 16'h0000, 16'h5000, 128'h0, 8'h06, 16'hFFFF, -1, 0, 0, 0),
      mk_res(16'h0000, 16'h55AA, 16'hFFFF, 20'h0FFFF, 1, 2'd3, 8, 2, 20'h0FFFF, 20'h00000)});
    vecs.push_back('{"seg_ovr",
      mk_op(1, 1, 1, 16'h1000, 16'h0000, 16'h5000, 128'h0, 8'h06, 16'hFFFF, -1, 0, 0, 0),
      mk_res(16'h0000, 16'h6677, 16'hFFFF, 20'h1FFFF, 1, 2'd3, 8, 2, 20'h1FFFF, 20'h10000)});
    vecs.push_back('{"stall_disp_hi",
      mk_op(1, 1, 0, 16'h0, 16'h0000, 16'h5000, 128'h0, 8'h06, 16'hFFFF, 2, 3, 0, 0),
      mk_res(16'h0000, 16'h55AA, 16'hFFFF, 20'h0FFFF, 1, 2'd3, 11, 2, 20'h0FFFF, 20'h00000)});
    vecs.push_back('{"lock_mid",
      mk_op(1, 1, 0, 16'h0, 16'h3000, 16'h2000, 128'h0000_0010_0100_0000_0000_0000_0000_BEEF,
            8'h42, 16'h00F0, -1, 0, 3, 2),
      mk_res(16'hBEEF, 16'h1234, 16'h0100, 20'h20100, 1, 2'd2, 9, 2, 20'h20100, 20'h20101)});
    vecs.push_back('{"byte_mem_bx",
      mk_op(0, 0, 0, 16'h0, 16'h0100, 16'h7000, 128'h0000_0000_0000_0000_2345_0000_1122_0000,
            8'h0F, 16'h0, -1, 0, 0, 0),
      mk_res(16'h009A, 16'h0022, 16'h2345, 20'h03345, 1, 2'd1, 4, 1, 20'h03345, 20'h0)});

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset.status", {28'd0, o_busy, o_done, o_ib_ready, o_mem_rd}, 32'd0);
    check("reset.mem_addr", 32'(o_mem_addr), 32'd0);
    check("reset.ops", {o_op1, o_op2}, 32'd0);
    check("reset.ea_phys", 32'(o_ea) | 32'(o_phys), 32'd0);
    check("reset.misc", {21'd0, o_modrm, o_is_mem, o_ip_inc}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i].op, vecs[i].exp, vecs[i].name);

    for (int i = 0; i < 40; i++) begin
      op = mk_op(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), {$urandom, $urandom, $urandom, $urandom}, 8'($urandom),
                 16'($urandom), $urandom_range(0, 4), $urandom_range(0, 3), 0, 0);
      e = model(op);
      if ($urandom_range(0, 3) == 0) begin
        op.lock_len = $urandom_range(1, 3);
        op.lock_at  = $urandom_range(1, 1 + 2 * e.nrd + int'(e.ip_inc) - 1);
        e = model(op);
      end
      run_op(op, e, $sformatf("rand%0d", i));
    end

    // Reset while the high byte is being read.
    @(negedge clock);
    i_size = 1'b1; i_dir = 1'b1; i_ovr_en = 1'b0; i_ds_seg = 16'h3000; i_ss_seg = 16'h2000;
    i_regs = 128'h0000_0010_0100_0000_0000_0000_0000_BEEF;
    i_start = 1'b1; i_ib_valid = 1'b1; i_ib_data = 8'h42;
    @(negedge clock);
    i_start = 1'b0;
    @(negedge clock);
    i_ib_data = 8'hF0;
    @(negedge clock);
    i_ib_valid = 1'b0;
    check("rst_mem.lo_rd", {11'd0, o_mem_rd, o_mem_addr}, {11'd0, 1'b1, 20'h20100});
    @(negedge clock);
    @(negedge clock);
    check("rst_mem.hi_rd", {11'd0, o_mem_rd, o_mem_addr}, {11'd0, 1'b1, 20'h20101});
    reset_n = 1'b0;
    @(negedge clock);
    check("rst_mem.after", {29'd0, o_busy, o_done, o_mem_rd}, 32'd0);
    check("rst_mem.cleared", {o_op2, o_ea}, 32'd0);
    reset_n = 1'b1;
    dones = 0;
    repeat (10) begin
      @(negedge clock);
      if (o_done) dones++;
    end
    check("rst_mem.no_done", 32'(dones), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
